// File: rtl/sampling_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sampling_tracker_pkg
//  Description : Shared constants and helpers for the multi-channel sampling
//                tracker front end: channel limit, CSR field widths and the
//                page-address extraction function.
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
package sampling_tracker_pkg;

    // Upper limit on snooped channels; the arbiter scan is sized to this.
    localparam int MAX_CHAN     = 8;
    // Width of the sample-period CSR field.
    localparam int CSR_PERIOD_W = 8;

    // Returns the upper data_size bits of an addr_size-bit address, right
    // aligned and zero-extended (page number at page granularity).
    function automatic logic [63:0] page_addr(input logic [63:0] addr,
                                              input int          addr_size,
                                              input int          data_size);
        logic [63:0] w_mask;
        w_mask = (64'd1 << data_size) - 64'd1;
        return (addr >> (addr_size - data_size)) & w_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sampling_tracker_mux_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : st_sync_fifo
//  Description : Synchronous first-word-fall-through FIFO with full/empty.
//                A write into a full FIFO is accepted when a read happens in
//                the same cycle.
//  Ports       : clk, rstn (sync, active-low)
//                i_wr_en / i_wr_data / o_full   - write side
//                i_rd_en / o_rd_data / o_empty  - read side (data valid
//                                                 whenever !o_empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module st_sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr;
    logic             w_rd;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd      = i_rd_en && !o_empty;
    assign w_wr      = i_wr_en && (!o_full || w_rd);
    assign o_rd_data = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/sampling_tracker_mux.sv
`default_nettype none
// ============================================================================
//  Module      : sampling_tracker_mux
//  Description : Snoops NUM_CHAN AXI AR/AW address channels, filters each
//                handshake by a CSR window and a 1-in-N sampler, buffers the
//                page address per channel and round-robin merges the buffers
//                into one valid/ready stream for the hot tracker.
//  Ports       : clk, rstn (sync, active-low)
//                ch_ar*/ch_aw*     - snooped address channels (packed/chan)
//                csr_*             - window, write-track and sample period
//                out_addr_valid/out_addr/out_chan/out_addr_ready - output
//                mem_chan_rd_en    - per-channel in-window AR handshake pulse
//                drop_cnt          - per-channel saturating drop counters
//  Revision    : 1.0 - initial multi-channel release
// ============================================================================
module sampling_tracker_mux
    import sampling_tracker_pkg::*;
#(
    parameter int NUM_CHAN   = 2,
    parameter int ADDR_SIZE  = 33,
    parameter int DATA_SIZE  = 21,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_CNT_W = 16
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [NUM_CHAN-1:0]              ch_arvalid,
    input  logic [NUM_CHAN-1:0]              ch_arready,
    input  logic [NUM_CHAN*ADDR_SIZE-1:0]    ch_araddr,
    input  logic [NUM_CHAN-1:0]              ch_awvalid,
    input  logic [NUM_CHAN-1:0]              ch_awready,
    input  logic [NUM_CHAN*ADDR_SIZE-1:0]    ch_awaddr,
    input  logic [ADDR_SIZE-1:0]             csr_addr_ub,
    input  logic [ADDR_SIZE-1:0]             csr_addr_lb,
    input  logic                             csr_range_en,
    input  logic                             csr_wr_track_en,
    input  logic [CSR_PERIOD_W-1:0]          csr_sample_period,
    output logic                             out_addr_valid,
    output logic [ADDR_SIZE-1:0]             out_addr,
    output logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0] out_chan,
    input  logic                             out_addr_ready,
    output logic [NUM_CHAN-1:0]              mem_chan_rd_en,
    output logic [NUM_CHAN*DROP_CNT_W-1:0]   drop_cnt
);
    localparam int CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int PW     = CSR_PERIOD_W;

    // ------------------------------------------------------------------
    // CSR shadow registers (quasi-static inputs, one cycle of delay)
    // ------------------------------------------------------------------
    logic [ADDR_SIZE-1:0] r_ub;
    logic [ADDR_SIZE-1:0] r_lb;
    logic                 r_range_en;
    logic                 r_wr_en;
    logic [PW-1:0]        r_period;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ub       <= '0;
            r_lb       <= '0;
            r_range_en <= 1'b0;
            r_wr_en    <= 1'b0;
            r_period   <= '0;
        end else begin
            r_ub       <= csr_addr_ub;
            r_lb       <= csr_addr_lb;
            r_range_en <= csr_range_en;
            r_wr_en    <= csr_wr_track_en;
            r_period   <= csr_sample_period;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel filter, sampler, capture register, FIFO, drop counter
    // ------------------------------------------------------------------
    logic [NUM_CHAN-1:0]  w_rd_fire;
    logic [NUM_CHAN-1:0]  w_avail;
    logic [NUM_CHAN-1:0]  w_take;
    logic [DATA_SIZE-1:0] w_head [NUM_CHAN];

    assign mem_chan_rd_en = w_rd_fire;

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        logic [ADDR_SIZE-1:0]  w_ar_addr;
        logic [ADDR_SIZE-1:0]  w_aw_addr;
        logic [ADDR_SIZE-1:0]  w_sel_addr;
        logic                  w_ar_in;
        logic                  w_aw_in;
        logic                  w_wr_fire;
        logic                  w_fire;
        logic                  w_keep;
        logic                  w_collide;
        logic [PW-1:0]         r_cnt;
        logic                  r_cap_v;
        logic [DATA_SIZE-1:0]  r_cap_d;
        logic                  w_fifo_wr;
        logic                  w_fifo_rd;
        logic                  w_fifo_full;
        logic                  w_fifo_empty;
        logic [DATA_SIZE-1:0]  w_fifo_dout;
        logic                  w_full_drop;
        logic [DROP_CNT_W-1:0] r_drop;
        logic [DROP_CNT_W:0]   w_drop_sum;

        assign w_ar_addr    = ch_araddr[i*ADDR_SIZE +: ADDR_SIZE];
        assign w_aw_addr    = ch_awaddr[i*ADDR_SIZE +: ADDR_SIZE];
        assign w_ar_in      = !r_range_en || ((w_ar_addr >= r_lb) && (w_ar_addr <= r_ub));
        assign w_aw_in      = !r_range_en || ((w_aw_addr >= r_lb) && (w_aw_addr <= r_ub));
        assign w_rd_fire[i] = ch_arvalid[i] && ch_arready[i] && w_ar_in;
        assign w_wr_fire    = ch_awvalid[i] && ch_awready[i] && w_aw_in && r_wr_en;
        assign w_fire       = w_rd_fire[i] || w_wr_fire;
        // Only one slot per channel per cycle: the read wins, the write drops.
        assign w_collide    = w_rd_fire[i] && w_wr_fire;
        assign w_sel_addr   = w_rd_fire[i] ? w_ar_addr : w_aw_addr;
        assign w_keep       = w_fire && ((r_period <= PW'(1)) || (r_cnt == '0));

        // The >= compare lets a shrinking period wrap a stale count cleanly.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_cnt <= '0;
            end else if (w_fire) begin
                if ((r_period <= PW'(1)) || (r_cnt >= r_period - PW'(1)))
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + PW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_cap_v <= 1'b0;
                r_cap_d <= '0;
            end else begin
                r_cap_v <= w_keep;
                if (w_keep)
                    r_cap_d <= DATA_SIZE'(page_addr(64'(w_sel_addr), ADDR_SIZE, DATA_SIZE));
            end
        end

        // A captured beat bypasses an empty FIFO straight into the output
        // register when granted; otherwise it is enqueued behind older ones.
        assign w_avail[i]  = r_cap_v || !w_fifo_empty;
        assign w_head[i]   = w_fifo_empty ? r_cap_d : w_fifo_dout;
        assign w_fifo_rd   = w_take[i] && !w_fifo_empty;
        assign w_fifo_wr   = r_cap_v && !(w_take[i] && w_fifo_empty);
        assign w_full_drop = w_fifo_wr && w_fifo_full && !w_fifo_rd;

        st_sync_fifo #(
            .WIDTH (DATA_SIZE),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rstn      (rstn),
            .i_wr_en   (w_fifo_wr),
            .i_wr_data (r_cap_d),
            .o_full    (w_fifo_full),
            .i_rd_en   (w_fifo_rd),
            .o_rd_data (w_fifo_dout),
            .o_empty   (w_fifo_empty)
        );

        // Collision and overflow drops can land in the same cycle (+2).
        assign w_drop_sum = {1'b0, r_drop}
                          + {{DROP_CNT_W{1'b0}}, w_collide}
                          + {{DROP_CNT_W{1'b0}}, w_full_drop};

        always_ff @(posedge clk) begin
            if (!rstn)
                r_drop <= '0;
            else if (w_drop_sum[DROP_CNT_W])
                r_drop <= '1;
            else
                r_drop <= w_drop_sum[DROP_CNT_W-1:0];
        end

        assign drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = r_drop;
    end

    // ------------------------------------------------------------------
    // Round-robin arbiter and output register
    // ------------------------------------------------------------------
    logic [CHAN_W-1:0]    r_rr_ptr;
    logic                 r_out_valid;
    logic [ADDR_SIZE-1:0] r_out_addr;
    logic [CHAN_W-1:0]    r_out_chan;
    logic                 w_any;
    logic                 w_load;
    logic [CHAN_W-1:0]    w_idx;
    logic [CHAN_W-1:0]    w_grant;
    logic [CHAN_W-1:0]    w_next_ptr;
    logic [NUM_CHAN-1:0]  w_grant_oh;
    logic [DATA_SIZE-1:0] w_grant_data;

    // First available channel at or after r_rr_ptr.
    always_comb begin
        w_any        = 1'b0;
        w_idx        = '0;
        w_grant      = '0;
        w_next_ptr   = '0;
        w_grant_oh   = '0;
        w_grant_data = '0;
        for (int k = 0; k < MAX_CHAN; k++) begin
            if ((k < NUM_CHAN) && !w_any) begin
                w_idx = CHAN_W'((int'(r_rr_ptr) + k) % NUM_CHAN);
                if (w_avail[w_idx]) begin
                    w_any             = 1'b1;
                    w_grant           = w_idx;
                    w_grant_oh[w_idx] = 1'b1;
                    w_grant_data      = w_head[w_idx];
                    w_next_ptr        = CHAN_W'((int'(w_idx) + 1) % NUM_CHAN);
                end
            end
        end
    end

    assign w_load = w_any && (!r_out_valid || out_addr_ready);
    assign w_take = w_grant_oh & {NUM_CHAN{w_load}};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_chan  <= '0;
            r_rr_ptr    <= '0;
        end else if (!r_out_valid || out_addr_ready) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_addr <= ADDR_SIZE'(w_grant_data);
                r_out_chan <= w_grant;
                r_rr_ptr   <= w_next_ptr;
            end
        end
    end

    assign out_addr_valid = r_out_valid;
    assign out_addr       = r_out_addr;
    assign out_chan       = r_out_chan;

endmodule
`default_nettype wire

// File: tb/tb_sampling_tracker_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sampling_tracker_mux
//  Description : Directed self-checking bench. A queue-based reference model
//                predicts, per channel, which page addresses must emerge and
//                in what order; a compare process checks every output beat,
//                hold stability and mem_chan_rd_en each cycle. Directed tests
//                add literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sampling_tracker_mux;
    localparam int NCH = 2;
    localparam int AS  = 33;
    localparam int DS  = 21;
    localparam int FD  = 16;
    localparam int DW  = 16;
    localparam int SH  = AS - DS;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]    ch_arvalid, ch_arready, ch_awvalid, ch_awready;
    logic [NCH*AS-1:0] ch_araddr, ch_awaddr;
    logic [AS-1:0]     csr_addr_ub, csr_addr_lb;
    logic              csr_range_en, csr_wr_track_en;
    logic [7:0]        csr_sample_period;
    logic              out_addr_valid;
    logic [AS-1:0]     out_addr;
    logic [0:0]        out_chan;
    logic              out_addr_ready;
    logic [NCH-1:0]    mem_chan_rd_en;
    logic [NCH*DW-1:0] drop_cnt;

    sampling_tracker_mux #(
        .NUM_CHAN   (NCH),
        .ADDR_SIZE  (AS),
        .DATA_SIZE  (DS),
        .FIFO_DEPTH (FD),
        .DROP_CNT_W (DW)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .ch_arvalid        (ch_arvalid),
        .ch_arready        (ch_arready),
        .ch_araddr         (ch_araddr),
        .ch_awvalid        (ch_awvalid),
        .ch_awready        (ch_awready),
        .ch_awaddr         (ch_awaddr),
        .csr_addr_ub       (csr_addr_ub),
        .csr_addr_lb       (csr_addr_lb),
        .csr_range_en      (csr_range_en),
        .csr_wr_track_en   (csr_wr_track_en),
        .csr_sample_period (csr_sample_period),
        .out_addr_valid    (out_addr_valid),
        .out_addr          (out_addr),
        .out_chan          (out_chan),
        .out_addr_ready    (out_addr_ready),
        .mem_chan_rd_en    (mem_chan_rd_en),
        .drop_cnt          (drop_cnt)
    );

    // ---------------- model state ----------------
    typedef struct packed {
        int              chan;
        longint unsigned addr;
    } exp_t;

    exp_t            mq[$];
    int              m_cnt  [NCH];
    int              m_drop [NCH];
    logic [NCH-1:0]  exp_rd_en;
    int              n_tests = 0;
    int              n_fail  = 0;
    int              n_out   = 0;
    int              rd_cnt0 = 0;
    int              seq[$];
    longint unsigned outs[$];

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input longint unsigned a);
        return !csr_range_en || ((a >= 64'(csr_addr_lb)) && (a <= 64'(csr_addr_ub)));
    endfunction

    // Decide, from the spec's rules, what this cycle's inputs must produce.
    task automatic model_eval();
        longint unsigned ar, aw, sel;
        bit rd, wr;
        for (int ch = 0; ch < NCH; ch++) begin
            ar = 64'(ch_araddr[ch*AS +: AS]);
            aw = 64'(ch_awaddr[ch*AS +: AS]);
            rd = ch_arvalid[ch] && ch_arready[ch] && in_rng(ar);
            wr = ch_awvalid[ch] && ch_awready[ch] && in_rng(aw) && csr_wr_track_en;
            exp_rd_en[ch] = rd;
            if (rd || wr) begin
                sel = rd ? ar : aw;
                if (csr_sample_period <= 1 || (m_cnt[ch] % int'(csr_sample_period)) == 0)
                    mq.push_back('{chan: ch, addr: sel >> SH});
                m_cnt[ch]++;
                if (rd && wr) m_drop[ch]++;
            end
        end
    endtask

    task automatic clear_in();
        ch_arvalid = '0; ch_arready = '0; ch_awvalid = '0; ch_awready = '0;
        exp_rd_en  = '0;
    endtask

    task automatic set_ar(input int ch, input longint unsigned a);
        ch_arvalid[ch] = 1'b1;
        ch_arready[ch] = 1'b1;
        ch_araddr[ch*AS +: AS] = AS'(a);
    endtask

    task automatic set_aw(input int ch, input longint unsigned a);
        ch_awvalid[ch] = 1'b1;
        ch_awready[ch] = 1'b1;
        ch_awaddr[ch*AS +: AS] = AS'(a);
    endtask

    task automatic step();
        model_eval();
        @(posedge clk); #1;
        clear_in();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_in();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_addr_valid, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_chan", out_chan, 0);
        chk("rst_rd_en", mem_chan_rd_en, 0);
        chk("rst_drop", drop_cnt, 0);
        mq.delete(); seq.delete(); outs.delete();
        for (int ch = 0; ch < NCH; ch++) begin m_cnt[ch] = 0; m_drop[ch] = 0; end
        n_out = 0; rd_cnt0 = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);
    endtask

    task automatic check_end(input string nm, input int exp_n);
        chk({nm, "_n_out"}, n_out, exp_n);
        chk({nm, "_model_drained"}, mq.size(), 0);
        for (int ch = 0; ch < NCH; ch++)
            chk({nm, "_drop_cnt"}, drop_cnt[ch*DW +: DW], m_drop[ch]);
    endtask

    // ---------------- compare process ----------------
    bit              prev_hold = 1'b0;
    longint unsigned hold_addr;
    int              hold_chan;

    always @(negedge clk) begin : cmp
        int idx;
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            for (int ch = 0; ch < NCH; ch++)
                chk("mem_chan_rd_en", mem_chan_rd_en[ch], exp_rd_en[ch]);
            rd_cnt0 += int'(mem_chan_rd_en[0]);
            if (prev_hold) begin
                chk("hold_valid", out_addr_valid, 1);
                chk("hold_addr", out_addr, hold_addr);
                chk("hold_chan", out_chan, hold_chan);
            end
            if (out_addr_valid) begin
                if (out_addr_ready) begin
                    n_out++;
                    seq.push_back(int'(out_chan));
                    outs.push_back(64'(out_addr));
                    idx = -1;
                    for (int j = 0; j < mq.size(); j++)
                        if (idx < 0 && mq[j].chan == int'(out_chan)) idx = j;
                    chk("out_beat_expected", (idx >= 0), 1);
                    if (idx >= 0) begin
                        chk("out_addr", out_addr, mq[idx].addr);
                        mq.delete(idx);
                    end
                end
                prev_hold = !out_addr_ready;
                hold_addr = 64'(out_addr);
                hold_chan = int'(out_chan);
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        ch_araddr = '0; ch_awaddr = '0;
        clear_in();
        csr_addr_ub = '0; csr_addr_lb = '0;
        csr_range_en = 1'b0; csr_wr_track_en = 1'b0; csr_sample_period = 8'd1;
        out_addr_ready = 1'b1;

        // T1: single AR, latency, rd_en pulse; valid without ready is ignored
        do_reset();
        ch_arvalid[0] = 1'b1; ch_araddr[0 +: AS] = 33'h0_5555_5000;
        step();
        set_ar(0, 64'h1_0000_0000);
        model_eval();
        @(negedge clk);
        chk("t1_rd_pulse", mem_chan_rd_en, 2'b01);
        @(posedge clk); #1;
        clear_in();
        @(negedge clk);
        chk("t1_valid_cyc1", out_addr_valid, 0);
        chk("t1_rd_pulse_end", mem_chan_rd_en, 2'b00);
        @(negedge clk);
        chk("t1_valid_cyc2", out_addr_valid, 1);
        chk("t1_addr", out_addr, 64'h10_0000);
        chk("t1_chan", out_chan, 0);
        @(posedge clk); #1;
        idle(4);
        check_end("t1", 1);

        // T2: both channels every cycle for 8 cycles -> strict alternation
        do_reset();
        for (int k = 0; k < 8; k++) begin
            set_ar(0, 64'h0_1000_0000 + 64'(k) * 64'h1000);
            set_ar(1, 64'h1_8000_0000 + 64'(k) * 64'h1000);
            step();
        end
        idle(25);
        check_end("t2", 16);
        for (int j = 0; j < seq.size(); j++)
            chk("t2_alternate", seq[j], j % 2);

        // T3: address window
        csr_addr_lb = 33'h1000; csr_addr_ub = 33'h1FFF; csr_range_en = 1'b1;
        do_reset();
        set_ar(0, 64'h0FFF); step();
        set_ar(0, 64'h1000); step();
        set_ar(0, 64'h1FFF); step();
        set_ar(0, 64'h2000); step();
        idle(6);
        check_end("t3", 2);
        chk("t3_rd_pulses", rd_cnt0, 2);
        for (int j = 0; j < outs.size(); j++)
            chk("t3_page", outs[j], 1);
        csr_range_en = 1'b0;

        // T4: period 4 keeps beats 1, 5, 9
        csr_sample_period = 8'd4;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            set_ar(0, 64'h1_0000_0000 + 64'(k) * 64'h1000);
            step();
        end
        idle(6);
        check_end("t4", 3);
        if (outs.size() == 3) begin
            chk("t4_out0", outs[0], 64'h10_0000);
            chk("t4_out1", outs[1], 64'h10_0004);
            chk("t4_out2", outs[2], 64'h10_0008);
        end
        csr_sample_period = 8'd1;

        // T5: backpressure overflow on ch1 -> 16 queued + 1 held, 3 dropped
        do_reset();
        out_addr_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            set_ar(1, 64'h0_4000_0000 + 64'(k) * 64'h1000);
            step();
        end
        repeat (3) void'(mq.pop_back());
        m_drop[1] += 3;
        idle(3);
        chk("t5_drop_ch1", drop_cnt[DW +: DW], 3);
        chk("t5_drop_ch0", drop_cnt[0 +: DW], 0);
        chk("t5_held_valid", out_addr_valid, 1);
        chk("t5_held_addr", out_addr, 64'h4_0000);
        out_addr_ready = 1'b1;
        idle(25);
        check_end("t5", 17);

        // T6: read/write collision, write tracking on and off
        csr_wr_track_en = 1'b1;
        do_reset();
        set_ar(0, 64'h1_2345_6000);
        set_aw(0, 64'h0_ABCD_E000);
        step();
        set_aw(1, 64'h0_7777_7000);
        step();
        idle(6);
        check_end("t6a", 2);
        chk("t6a_drop_lit", drop_cnt[0 +: DW], 1);
        csr_wr_track_en = 1'b0;
        idle(2);
        set_ar(0, 64'h1_2345_6000);
        set_aw(0, 64'h0_ABCD_E000);
        step();
        idle(6);
        check_end("t6b", 3);
        chk("t6b_drop_lit", drop_cnt[0 +: DW], 1);

        // T7: reset while entries are queued discards them
        do_reset();
        out_addr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_ar(0, 64'h0_2000_0000 + 64'(k) * 64'h1000);
            step();
        end
        out_addr_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("t7_no_beat", out_addr_valid, 0);
        @(posedge clk); #1;
        idle(6);
        check_end("t7", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sampling_tracker_mux.md
Name: sampling_tracker_mux

Overview:
Multi-channel successor to the single-channel sampling tracker front end. It snoops NUM_CHAN memory-controller AXI address channels, reads and optionally writes. Each handshaked address is filtered by a CSR address window and a 1-in-N sampler, then buffered per channel. Buffered addresses are round-robin arbitrated into a single valid/ready stream that feeds the hot tracker input, with per-channel drop counters for overflow.

Parameters:
NUM_CHAN, 2, number of snooped memory channels (1..8)
ADDR_SIZE, 33, address width
DATA_SIZE, 21, upper address bits kept (page granularity)
FIFO_DEPTH, 16, entries per channel FIFO (power of 2, >=2)
DROP_CNT_W, 16, drop counter width

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
ch_arvalid  in  NUM_CHAN  per-channel AR valid
ch_arready  in  NUM_CHAN  per-channel AR ready
ch_araddr  in  NUM_CHAN*ADDR_SIZE  AR address; channel i at [i*ADDR_SIZE +: ADDR_SIZE]
ch_awvalid  in  NUM_CHAN  per-channel AW valid
ch_awready  in  NUM_CHAN  per-channel AW ready
ch_awaddr  in  NUM_CHAN*ADDR_SIZE  AW address, same packing as ch_araddr
csr_addr_ub  in  ADDR_SIZE  window upper bound, inclusive
csr_addr_lb  in  ADDR_SIZE  window lower bound, inclusive
csr_range_en  in  1  1 = apply window; 0 = all addresses pass
csr_wr_track_en  in  1  1 = also track writes
csr_sample_period  in  8  forward every Nth qualifying beat; 0 and 1 = every beat
out_addr_valid  out  1  tracker input valid
out_addr  out  ADDR_SIZE  zero-extended upper DATA_SIZE address bits
out_chan  out  $clog2(NUM_CHAN)  source channel (width 1 when NUM_CHAN=1)
out_addr_ready  in  1  tracker ready
mem_chan_rd_en  out  NUM_CHAN  pulse per AR handshake that passes the window (pre-sampling)
drop_cnt  out  NUM_CHAN*DROP_CNT_W  saturating per-channel drop counts

Behaviour:
- Reset: out_addr_valid=0, out_addr=0, out_chan=0, mem_chan_rd_en=0, drop_cnt=0. All FIFOs empty, sample counters 0, RR pointer 0.
- CSR inputs are registered once at clk and are quasi-static; changes take effect 1 cycle later.
- Fire, per channel:
  - rd_fire = arvalid & arready & in_range.
  - wr_fire = awvalid & awready & in_range & wr_track_en.
  - in_range = !range_en | (lb <= addr[ADDR_SIZE-1:0] <= ub), unsigned compare.
- mem_chan_rd_en[i] is combinational from rd_fire[i]. Not affected by sampling or drops.
- Simultaneous rd_fire and wr_fire on one channel: read takes the slot; the write counts as a drop.
- Sampler, per channel:
  - Counter increments on each fire and wraps to 0 at period-1.
  - Beat is kept when counter==0 before the increment.
  - Period 0/1 keeps every beat.
  - A period change resets no counter; the counter is compared modulo the new period using >= period-1 → wrap.
- Capture register, 1 cycle: kept beat → enqueue {zero-extend, addr[ADDR_SIZE-1 -: DATA_SIZE]} into channel FIFO.
- FIFO full at enqueue: entry discarded and drop_cnt[i]++, saturating at all-ones.
  - Enqueue and dequeue in the same cycle on a full FIFO succeeds; no drop.
- Arbiter:
  - Output register is loaded when (!out_addr_valid | out_addr_ready) and any FIFO is non-empty.
  - Grant goes to the first non-empty channel at or after rr_ptr. rr_ptr <= grant+1 mod NUM_CHAN.
  - out_addr and out_chan are held stable while valid & !ready.
- Throughput: 1 address/cycle total. Latency from AXI handshake to out_addr_valid = 2 cycles minimum (capture, FIFO+arb register), when the FIFO is empty and output is idle.
- Reset mid-operation: all queued entries are discarded; no output beat for 1 cycle after rstn rises.

Decomposition:
- Package sampling_tracker_pkg: MAX_CHAN=8, CSR field widths, and the helper function for page-address extraction.
- Sub-module st_sync_fifo: parameterised (WIDTH, DEPTH) synchronous FIFO, first-word fall-through, with full/empty flags. Instantiated NUM_CHAN times via generate.
- Arbiter and sampler stay inline.

Test Plan:
- Single AR on ch0, addr 0x1_0000_0000, range off, period 1, ready=1 → out_addr=0x0_0010_0000 (addr>>12, zero-extended), out_chan=0, valid 2 cycles after handshake; mem_chan_rd_en[0] one-cycle pulse.
- ch0 and ch1 AR every cycle for 8 cycles, ready=1 → outputs alternate ch0,ch1; total 16 beats; no drops with FIFO_DEPTH=16.
- Window lb=0x1000, ub=0x1FFF, range_en=1: addrs 0x0FFF, 0x1000, 0x1FFF, 0x2000 → only 0x1000 and 0x1FFF emitted; mem_chan_rd_en pulses 2 times.
- period=4, 12 AR beats on ch0 → exactly beats 1, 5, 9 emitted (3 outputs).
- out_addr_ready=0, 20 AR beats on ch1 → 16 queued + 1 in output reg; drop_cnt[1]=3; after ready=1, 17 beats emerge in order.
- wr_track_en=1, same-cycle AR+AW on ch0 → 1 output (read address), drop_cnt[0]=1; with wr_track_en=0 → no drop.
